input_router_vc: RTL and testbench
==================================

Name: input_router_vc

Overview:
- Parametrised successor to the single-channel NoC input router.
- Decodes head flits arriving at one router input port using dimension-ordered XY routing.
- Keeps a per-virtual-channel routing table so that body and tail flits of each packet follow their head flit.
- Presents a registered one-hot output-port request, with a valid/ready handshake, to the switch allocator.

Parameters:
- FLIT_WIDTH, 37: total flit width.
- NUM_VC, 4: number of virtual channels (1..16); VC_W = max(1, clog2(NUM_VC)).
- X_W, 2: width of the destination X coordinate field.
- Y_W, 2: width of the destination Y coordinate field.
- ROUTER_X, 0: X coordinate of this router.
- ROUTER_Y, 0: Y coordinate of this router.

Ports:
- clk  in  1  clock
- arst  in  1  reset, synchronous, active-high
- flit_valid_i  in  1  upstream flit valid
- flit_i  in  FLIT_WIDTH  flit; [FLIT_WIDTH-1:FLIT_WIDTH-2]=type (00 head, 01 body, 10 tail, 11 head_tail); header destination X at [X_W-1:0], destination Y at [X_W+Y_W-1:X_W]
- vc_id_i  in  VC_W  virtual channel of the flit
- flit_ready_o  out  1  upstream ready
- route_valid_o  out  1  registered route request valid
- router_port_o  out  5  one-hot port: bit0 local, bit1 north, bit2 south, bit3 west, bit4 east
- route_vc_o  out  VC_W  VC of the request
- route_flit_o  out  FLIT_WIDTH  registered flit
- route_ready_i  in  1  downstream accept
- err_o  out  1  sticky protocol error

Behaviour:
- Reset:
  - clk and arst: one clock; reset is synchronous and active-high.
  - While arst is high at a clk edge: route_valid_o=0, router_port_o=0, route_vc_o=0, route_flit_o=0, err_o=0.
  - All NUM_VC table entries are cleared (valid=0, port=0).
  - Reset asserted mid-packet discards the packet state; after reset, a body flit on that VC is treated as orphan.
- Handshake:
  - flit_ready_o = !route_valid_o || route_ready_i (combinational).
  - A flit is accepted when flit_valid_i && flit_ready_o.
  - Output register: loads on acceptance; holds while route_valid_o && !route_ready_i; clears valid when route_ready_i && nothing is accepted.
  - Latency is 1 cycle from acceptance to route_valid_o.
  - Full throughput of 1 flit/cycle when route_ready_i is held high.
- XY route (head and head_tail flits):
  - Comparisons are unsigned.
  - dest_x > ROUTER_X -> east; dest_x < ROUTER_X -> west.
  - Otherwise dest_y > ROUTER_Y -> north; dest_y < ROUTER_Y -> south.
  - Otherwise local.
- Table update on acceptance:
  - head: table[vc] <= {valid=1, port}; if the entry was already valid, set err_o (overwrite still happens).
  - head_tail: output uses the computed port; table[vc] is left invalid.
  - body: if table[vc] is valid, output port = table[vc].port; otherwise orphan.
  - tail: same as body, then table[vc].valid <= 0.
- Orphan body/tail flit (no valid entry on its VC):
  - flit is consumed; route_valid_o stays 0 for it; err_o is set.
  - An orphan tail leaves the entry invalid.
- Simultaneous events:
  - A head on VC a and a tail on VC b cannot coincide (one flit per cycle).
  - A head accepted in the same cycle the previous tail on the same VC is being output: the table already holds valid=0, so no error is raised.
- Table state is per VC and independent; interleaved packets on different VCs do not interact.
- err_o clears only on reset.
- route_flit_o and route_vc_o are stable while route_valid_o && !route_ready_i.

Test Plan:
- ROUTER_X=1, ROUTER_Y=1; head on VC0 with dest (3,0) -> next cycle route_valid_o=1, router_port_o=5'b10000 (east), route_vc_o=0; body and tail on VC0 -> port 5'b10000 each; then a body on VC0 -> err_o=1, no route_valid_o.
- Head dest (1,1) on VC2, head dest (0,2) on VC3, body VC2, body VC3, tail VC3, tail VC2 -> ports local, west, local, west, west, local; no error.
- head_tail dest (1,3) -> 5'b00010 (north); the next body on that VC is flagged as an error.
- Hold route_ready_i=0 for 3 cycles with route_valid_o=1 -> flit_ready_o=0; outputs stable; on release, one transfer occurs per cycle with no loss or duplication.
- Head on VC1 dest (2,1), then arst pulsed high for 1 cycle, then body on VC1 -> after reset all outputs are 0; the body is orphaned and err_o=1.
- Second head on VC0 while VC0 is open -> err_o=1; subsequent body flits use the new port.

Source files
------------

// File: rtl/input_router_vc.sv
// input_router_vc: XY route decode for one router input port.
// Head flits compute an XY route; body and tail flits reuse the port that their
// head stored in a per-VC table. The route request leaves through a one-stage
// registered valid/ready slot.

// Per-VC routing table entry: opened by a head, closed by a tail.
module input_router_vc_entry #(
   parameter int PW = 5
) (
   input  logic          clk,
   input  logic          arst,
   input  logic          wr_head,
   input  logic          clr,
   input  logic [PW-1:0] port_in,
   output logic          vld,
   output logic [PW-1:0] port
);

   // A head always overwrites; a tail closes the entry.
   always_ff @(posedge clk) begin
      if (arst) begin
         vld  <= 1'b0;
         port <= '0;
      end else if (wr_head) begin
         vld  <= 1'b1;
         port <= port_in;
      end else if (clr) begin
         vld  <= 1'b0;
      end
   end

endmodule

module input_router_vc #(
   parameter  int FLIT_WIDTH = 37,
   parameter  int NUM_VC     = 4,
   parameter  int X_W        = 2,
   parameter  int Y_W        = 2,
   parameter  int ROUTER_X   = 0,
   parameter  int ROUTER_Y   = 0,
   localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  flit_valid_i,
   input  logic [FLIT_WIDTH-1:0] flit_i,
   input  logic [VC_W-1:0]       vc_id_i,
   output logic                  flit_ready_o,
   output logic                  route_valid_o,
   output logic [4:0]            router_port_o,
   output logic [VC_W-1:0]       route_vc_o,
   output logic [FLIT_WIDTH-1:0] route_flit_o,
   input  logic                  route_ready_i,
   output logic                  err_o
);

   localparam logic [1:0] T_HEAD = 2'b00;
   localparam logic [1:0] T_BODY = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_HT   = 2'b11;

   localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
   localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

   localparam logic [4:0] P_LOCAL = 5'b00001;
   localparam logic [4:0] P_NORTH = 5'b00010;
   localparam logic [4:0] P_SOUTH = 5'b00100;
   localparam logic [4:0] P_WEST  = 5'b01000;
   localparam logic [4:0] P_EAST  = 5'b10000;

   logic [1:0]              ftype;
   logic [X_W-1:0]          dest_x;
   logic [Y_W-1:0]          dest_y;
   logic                    accept;
   logic [4:0]              xy_port;
   logic                    hit;
   logic [4:0]              hit_port;
   logic                    out_vld;
   logic [4:0]              out_port;
   logic                    set_err;
   logic [NUM_VC-1:0]       tbl_vld;
   logic [NUM_VC-1:0][4:0]  tbl_port;

   assign ftype        = flit_i[FLIT_WIDTH-1 -: 2];
   assign dest_x       = flit_i[X_W-1:0];
   assign dest_y       = flit_i[X_W+Y_W-1:X_W];
   assign flit_ready_o = !route_valid_o || route_ready_i;
   assign accept       = flit_valid_i && flit_ready_o;

   // Dimension-ordered route: resolve X first, then Y, else local.
   always_comb begin
      xy_port = P_LOCAL;
      if (dest_x > RX)      xy_port = P_EAST;
      else if (dest_x < RX) xy_port = P_WEST;
      else if (dest_y > RY) xy_port = P_NORTH;
      else if (dest_y < RY) xy_port = P_SOUTH;
   end

   // Table lookup by VC; an out-of-range VC simply never hits.
   always_comb begin
      hit      = 1'b0;
      hit_port = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (vc_id_i == VC_W'(i)) begin
            hit      = tbl_vld[i];
            hit_port = tbl_port[i];
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_VC; g++) begin : g_vc
         logic sel;
         assign sel = accept && (vc_id_i == VC_W'(g));
         input_router_vc_entry #(.PW(5)) u_entry (
            .clk     (clk),
            .arst    (arst),
            .wr_head (sel && (ftype == T_HEAD)),
            .clr     (sel && (ftype == T_TAIL)),
            .port_in (xy_port),
            .vld     (tbl_vld[g]),
            .port    (tbl_port[g])
         );
      end
   endgenerate

   // Select the outgoing port and flag duplicate heads and orphan flits.
   always_comb begin
      out_vld  = 1'b0;
      out_port = '0;
      set_err  = 1'b0;
      case (ftype)
         T_HEAD: begin
            out_vld  = 1'b1;
            out_port = xy_port;
            set_err  = hit;
         end
         T_HT: begin
            out_vld  = 1'b1;
            out_port = xy_port;
         end
         T_BODY, T_TAIL: begin
            out_vld  = hit;
            out_port = hit_port;
            set_err  = !hit;
         end
         default: ;
      endcase
   end

   // Output slot: load on acceptance, hold under backpressure, drain on ready.
   always_ff @(posedge clk) begin
      if (arst) begin
         route_valid_o <= 1'b0;
         router_port_o <= '0;
         route_vc_o    <= '0;
         route_flit_o  <= '0;
      end else if (accept) begin
         route_valid_o <= out_vld;
         if (out_vld) begin
            router_port_o <= out_port;
            route_vc_o    <= vc_id_i;
            route_flit_o  <= flit_i;
         end
      end else if (route_ready_i) begin
         route_valid_o <= 1'b0;
      end
   end

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk) begin
      if (arst)                    err_o <= 1'b0;
      else if (accept && set_err)  err_o <= 1'b1;
   end

endmodule

// File: tb/tb_input_router_vc.sv
// Directed bench for input_router_vc with the router placed at (1,1).
module tb_input_router_vc;

   localparam int FW = 37;
   localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, HT = 2'b11;

   logic          clk = 1'b0;
   logic          arst;
   logic          flit_valid_i;
   logic [FW-1:0] flit_i;
   logic [1:0]    vc_id_i;
   logic          flit_ready_o;
   logic          route_valid_o;
   logic [4:0]    router_port_o;
   logic [1:0]    route_vc_o;
   logic [FW-1:0] route_flit_o;
   logic          route_ready_i;
   logic          err_o;

   int n_chk  = 0;
   int n_fail = 0;

   input_router_vc #(
      .FLIT_WIDTH(FW), .NUM_VC(4), .X_W(2), .Y_W(2), .ROUTER_X(1), .ROUTER_Y(1)
   ) dut (
      .clk(clk), .arst(arst), .flit_valid_i(flit_valid_i), .flit_i(flit_i),
      .vc_id_i(vc_id_i), .flit_ready_o(flit_ready_o), .route_valid_o(route_valid_o),
      .router_port_o(router_port_o), .route_vc_o(route_vc_o), .route_flit_o(route_flit_o),
      .route_ready_i(route_ready_i), .err_o(err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] tag,
                                        input logic [1:0] x, input logic [1:0] y);
      return {t, 23'd0, tag, y, x};
   endfunction

   // Offer one flit for one cycle (called and returning at a negedge).
   task automatic drive(input logic [1:0] t, input logic [1:0] vc, input logic [1:0] x,
                        input logic [1:0] y, input logic [7:0] tag, output logic [FW-1:0] f);
      f            = mk(t, tag, x, y);
      flit_valid_i = 1'b1;
      flit_i       = f;
      vc_id_i      = vc;
      @(negedge clk);
      flit_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst = 1'b1; flit_valid_i = 1'b0;
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({route_valid_o, router_port_o, route_vc_o, route_flit_o, err_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b p=%b vc=%0d flit=%h err=%b, want all 0",
                  route_valid_o, router_port_o, route_vc_o, route_flit_o, err_o);
      end
      n_chk++;
      if (flit_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", flit_ready_o);
      end
   endtask

   task automatic test_east_packet();
      logic [FW-1:0] f;
      logic [1:0] ts [3] = '{HD, BD, TL};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(ts[i], 2'd0, 2'd3, 2'd0, 8'(8'h10 + i), f);
         n_chk++;
         if ({route_valid_o, router_port_o, route_vc_o, route_flit_o} !== {1'b1, 5'b10000, 2'd0, f}) begin
            n_fail++;
            $display("FAIL east_flit%0d: got v=%b p=%b vc=%0d flit=%h, want v=1 p=10000 vc=0 flit=%h",
                     i, route_valid_o, router_port_o, route_vc_o, route_flit_o, f);
         end
      end
      drive(BD, 2'd0, 2'd0, 2'd0, 8'h13, f);
      n_chk++;
      if ({route_valid_o, err_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL east_orphan: got v=%b err=%b, want v=0 err=1", route_valid_o, err_o);
      end
   endtask

   task automatic test_interleave();
      logic [FW-1:0] f;
      logic [1:0] ts  [6] = '{HD, HD, BD, BD, TL, TL};
      logic [1:0] vcs [6] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
      logic [1:0] xs  [6] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      logic [1:0] ys  [6] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
      logic [4:0] ps  [6] = '{5'b00001, 5'b01000, 5'b00001, 5'b01000, 5'b01000, 5'b00001};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(ts[i], vcs[i], xs[i], ys[i], 8'(8'h20 + i), f);
         n_chk++;
         if ({route_valid_o, router_port_o, route_vc_o, route_flit_o} !== {1'b1, ps[i], vcs[i], f}) begin
            n_fail++;
            $display("FAIL interleave%0d: got v=%b p=%b vc=%0d, want v=1 p=%b vc=%0d",
                     i, route_valid_o, router_port_o, route_vc_o, ps[i], vcs[i]);
         end
      end
      n_chk++;
      if (err_o !== 1'b0) begin
         n_fail++; $display("FAIL interleave_err: got %b want 0", err_o);
      end
   endtask

   task automatic test_head_tail();
      logic [FW-1:0] f;
      do_reset();
      drive(HT, 2'd1, 2'd1, 2'd3, 8'h30, f);
      n_chk++;
      if ({route_valid_o, router_port_o, route_vc_o, route_flit_o} !== {1'b1, 5'b00010, 2'd1, f}) begin
         n_fail++;
         $display("FAIL ht_north: got v=%b p=%b vc=%0d, want v=1 p=00010 vc=1",
                  route_valid_o, router_port_o, route_vc_o);
      end
      drive(BD, 2'd1, 2'd0, 2'd0, 8'h31, f);
      n_chk++;
      if ({route_valid_o, err_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL ht_orphan: got v=%b err=%b, want v=0 err=1", route_valid_o, err_o);
      end
   endtask

   task automatic test_backpressure();
      logic [FW-1:0] fh, fb, ft;
      do_reset();
      route_ready_i = 1'b0;
      drive(HD, 2'd0, 2'd2, 2'd1, 8'h40, fh);
      fb = mk(BD, 8'h41, 2'd0, 2'd0);
      flit_valid_i = 1'b1; flit_i = fb; vc_id_i = 2'd0;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if ({flit_ready_o, route_valid_o, router_port_o, route_vc_o, route_flit_o} !==
             {1'b0, 1'b1, 5'b10000, 2'd0, fh}) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got rdy=%b v=%b p=%b flit=%h, want rdy=0 v=1 p=10000 flit=%h",
                     i, flit_ready_o, route_valid_o, router_port_o, route_flit_o, fh);
         end
         @(negedge clk);
      end
      route_ready_i = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({route_valid_o, router_port_o, route_flit_o} !== {1'b1, 5'b10000, fb}) begin
         n_fail++;
         $display("FAIL bp_body: got v=%b p=%b flit=%h, want v=1 p=10000 flit=%h",
                  route_valid_o, router_port_o, route_flit_o, fb);
      end
      drive(TL, 2'd0, 2'd0, 2'd0, 8'h42, ft);
      n_chk++;
      if ({route_valid_o, router_port_o, route_flit_o} !== {1'b1, 5'b10000, ft}) begin
         n_fail++;
         $display("FAIL bp_tail: got v=%b p=%b flit=%h, want v=1 p=10000 flit=%h",
                  route_valid_o, router_port_o, route_flit_o, ft);
      end
      @(negedge clk);
      n_chk++;
      if ({route_valid_o, err_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL bp_drain: got v=%b err=%b, want v=0 err=0", route_valid_o, err_o);
      end
   endtask

   task automatic test_mid_reset();
      logic [FW-1:0] f;
      do_reset();
      drive(HD, 2'd1, 2'd2, 2'd1, 8'h50, f);
      n_chk++;
      if ({route_valid_o, router_port_o, route_vc_o} !== {1'b1, 5'b10000, 2'd1}) begin
         n_fail++;
         $display("FAIL mr_head: got v=%b p=%b vc=%0d, want v=1 p=10000 vc=1",
                  route_valid_o, router_port_o, route_vc_o);
      end
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      n_chk++;
      if ({route_valid_o, router_port_o, route_vc_o, route_flit_o, err_o} !== '0) begin
         n_fail++;
         $display("FAIL mr_cleared: got v=%b p=%b vc=%0d flit=%h err=%b, want all 0",
                  route_valid_o, router_port_o, route_vc_o, route_flit_o, err_o);
      end
      drive(BD, 2'd1, 2'd0, 2'd0, 8'h51, f);
      n_chk++;
      if ({route_valid_o, err_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL mr_orphan: got v=%b err=%b, want v=0 err=1", route_valid_o, err_o);
      end
   endtask

   task automatic test_double_head();
      logic [FW-1:0] f;
      do_reset();
      drive(HD, 2'd0, 2'd3, 2'd1, 8'h60, f);
      n_chk++;
      if ({route_valid_o, router_port_o, err_o} !== {1'b1, 5'b10000, 1'b0}) begin
         n_fail++;
         $display("FAIL dh_first: got v=%b p=%b err=%b, want v=1 p=10000 err=0",
                  route_valid_o, router_port_o, err_o);
      end
      drive(HD, 2'd0, 2'd1, 2'd0, 8'h61, f);
      n_chk++;
      if ({route_valid_o, router_port_o, err_o} !== {1'b1, 5'b00100, 1'b1}) begin
         n_fail++;
         $display("FAIL dh_second: got v=%b p=%b err=%b, want v=1 p=00100 err=1",
                  route_valid_o, router_port_o, err_o);
      end
      drive(BD, 2'd0, 2'd0, 2'd0, 8'h62, f);
      n_chk++;
      if ({route_valid_o, router_port_o, route_flit_o} !== {1'b1, 5'b00100, f}) begin
         n_fail++;
         $display("FAIL dh_body: got v=%b p=%b, want v=1 p=00100", route_valid_o, router_port_o);
      end
   endtask

   initial begin
      arst = 1'b1; flit_valid_i = 1'b0; flit_i = '0; vc_id_i = '0; route_ready_i = 1'b1;
      test_reset();
      test_east_packet();
      test_interleave();
      test_head_tail();
      test_backpressure();
      test_mid_reset();
      test_double_head();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
